// File: rtl/truth_table_probe_pkg.sv
// Shared types and sizing for the truth-table probe: FSM states and
// truth-table geometry for 3-input, single-output gates.
package truth_table_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int CODE_W      = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/truth_table_probe_if.sv
// Probe-side bus: gate stimulus/response plus sweep control and result.
// master = harness driving start/dut_out, slave = the probe itself.
interface truth_table_probe_if;
    import truth_table_pkg::*;

    logic              start;
    logic              in1;
    logic              in2;
    logic              in3;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              unstable;

    modport master (
        output start, dut_out,
        input  in1, in2, in3, busy, done, code, valid, unstable
    );

    modport slave (
        input  start, dut_out,
        output in1, in2, in3, busy, done, code, valid, unstable
    );

endinterface

// File: rtl/truth_table_probe.sv
// Sweeps a 3-input gate through all 8 input vectors, double-samples its
// output per vector and assembles the 8-bit truth-table code (idx 0 -> MSB).
module truth_table_probe
    import truth_table_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic               clk,
    input  logic               reset,
    truth_table_probe_if.slave bus
);

    localparam int                CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("truth_table_probe: SETTLE must be >= 1");
    end

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CODE_W-1:0] r_acc, w_acc_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic              r_sample_a, w_sample_a_nxt;
    logic              r_sticky, w_sticky_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_unstable, w_unstable_nxt;
    logic [IDX_W-1:0]  w_bitpos;

    assign w_bitpos = IDX_LAST - r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_code     <= '0;
            r_sample_a <= 1'b0;
            r_sticky   <= 1'b0;
            r_valid    <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_code     <= w_code_nxt;
            r_sample_a <= w_sample_a_nxt;
            r_sticky   <= w_sticky_nxt;
            r_valid    <= w_valid_nxt;
            r_unstable <= w_unstable_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_code_nxt     = r_code;
        w_sample_a_nxt = r_sample_a;
        w_sticky_nxt   = r_sticky;
        w_valid_nxt    = r_valid;
        w_unstable_nxt = r_unstable;

        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = '0;
                if (bus.start) begin
                    w_state_nxt  = ST_SETTLE;
                    w_cnt_nxt    = '0;
                    w_acc_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                    w_valid_nxt  = 1'b0;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_sample_a_nxt = bus.dut_out;
                    w_state_nxt    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_acc_nxt[w_bitpos] = bus.dut_out;
                w_sticky_nxt        = r_sticky | (r_sample_a != bus.dut_out);
                if (r_idx == IDX_LAST) begin
                    // Result registers load on the edge into DONE so code/valid
                    // are already valid during the done pulse.
                    w_state_nxt    = ST_DONE;
                    w_code_nxt     = w_acc_nxt;
                    w_unstable_nxt = w_sticky_nxt;
                    w_valid_nxt    = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign bus.in1      = r_idx[2];
    assign bus.in2      = r_idx[1];
    assign bus.in3      = r_idx[0];
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.code     = r_code;
    assign bus.valid    = r_valid;
    assign bus.unstable = r_unstable;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: known gates, glitch injection,
// mid-sweep reset, back-to-back sweeps and a lagging gate at two SETTLE values.
module tb_truth_table_probe;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   gate_sel;
    logic inv;
    logic w_g;
    logic r_lag0, r_lag1;

    truth_table_probe_if bus0 ();
    truth_table_probe_if bus1 ();

    truth_table_probe #(.SETTLE(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    truth_table_probe #(.SETTLE(1)) u_dut_s1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Gate models: 0 in2, 1 NOR3, 2 const 1, 3 const 0, 4 in2 delayed a cycle
    always_comb begin
        case (gate_sel)
            0:       w_g = bus0.in2;
            1:       w_g = ~(bus0.in1 | bus0.in2 | bus0.in3);
            2:       w_g = 1'b1;
            3:       w_g = 1'b0;
            default: w_g = r_lag0;
        endcase
        bus0.dut_out = w_g ^ inv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lag0 <= 1'b0;
            r_lag1 <= 1'b0;
        end else begin
            r_lag0 <= bus0.in2;
            r_lag1 <= bus1.in2;
        end
    end

    assign bus1.dut_out = r_lag1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stim"},     {bus0.in1, bus0.in2, bus0.in3}, 0);
        check({tag, "_busy"},     bus0.busy, 0);
        check({tag, "_done"},     bus0.done, 0);
        check({tag, "_code"},     bus0.code, 8'h00);
        check({tag, "_valid"},    bus0.valid, 0);
        check({tag, "_unstable"}, bus0.unstable, 0);
    endtask

    // Start one sweep on the SETTLE=4 probe; optionally invert dut_out in cycle inv_cycle.
    task automatic run_sweep(input string tag, input logic [7:0] exp_code,
                             input logic exp_unst, input int inv_cycle);
        int  c;
        bit  got;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        c   = 1;
        got = 1'b0;
        check({tag, "_busy1"}, bus0.busy, 1);
        while (c < 100 && !got) begin
            if (c <= 36 && (c - 1) % 5 == 0)
                check({tag, "_stim"}, {bus0.in1, bus0.in2, bus0.in3}, (c - 1) / 5);
            inv = (c == inv_cycle);
            if (bus0.done) got = 1'b1;
            else begin
                tick();
                c++;
            end
        end
        inv = 1'b0;
        check({tag, "_done_cycle"}, c, 41);
        check({tag, "_code"},       bus0.code, exp_code);
        check({tag, "_valid"},      bus0.valid, 1);
        check({tag, "_unstable"},   bus0.unstable, exp_unst);
        tick();
        check({tag, "_done_low"},   bus0.done, 0);
        check({tag, "_busy_low"},   bus0.busy, 0);
        check({tag, "_stim_idle"},  {bus0.in1, bus0.in2, bus0.in3}, 0);
        check({tag, "_code_hold"},  bus0.code, exp_code);
    endtask

    initial begin
        int dpos [3];
        int n;
        int seen;
        int c;
        bit got;

        reset      = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        gate_sel   = 0;
        inv        = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        gate_sel = 0; run_sweep("in2",    8'h33, 1'b0, 0);
        gate_sel = 1; run_sweep("nor",    8'h80, 1'b0, 0);
        gate_sel = 2; run_sweep("one",    8'hFF, 1'b0, 0);
        gate_sel = 3; run_sweep("zero",   8'h00, 1'b0, 0);
        gate_sel = 0; run_sweep("glitch", 8'h37, 1'b1, 30);

        // Mid-sweep reset in cycle 20
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        check("midrst_valid_drop", bus0.valid, 0);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("midrst");
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus0.done) seen++;
        end
        check("midrst_no_done", seen, 0);
        run_sweep("after_rst", 8'h33, 1'b0, 0);

        // start held high: back-to-back sweeps
        dpos = '{-1, -1, -1};
        n    = 0;
        bus0.start = 1'b1;
        for (int k = 1; k <= 200 && n < 3; k++) begin
            tick();
            if (k == 42) begin
                check("b2b_idle_done", bus0.done, 0);
                check("b2b_idle_busy", bus0.busy, 0);
            end
            if (k == 43) check("b2b_valid_drop", bus0.valid, 0);
            if (bus0.done) begin
                dpos[n] = k;
                n++;
                if (n == 3) bus0.start = 1'b0;
            end
        end
        bus0.start = 1'b0;
        check("b2b_done1", dpos[0], 41);
        check("b2b_done2", dpos[1], 83);
        check("b2b_done3", dpos[2], 125);
        check("b2b_code",  bus0.code, 8'h33);
        tick();
        tick();
        check("b2b_stop_busy", bus0.busy, 0);

        // Lagging gate: tolerated with SETTLE=4, flagged with SETTLE=1
        gate_sel = 4; run_sweep("lag4", 8'h33, 1'b0, 0);

        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        c   = 1;
        got = 1'b0;
        while (c < 60 && !got) begin
            if (bus1.done) got = 1'b1;
            else begin
                tick();
                c++;
            end
        end
        check("lag1_done_cycle", c, 17);
        check("lag1_code",       bus1.code, 8'h33);
        check("lag1_valid",      bus1.valid, 1);
        check("lag1_unstable",   bus1.unstable, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
